// File: rtl/gated_combine_pipe.sv
// gated_combine_pipe: per-lane A/D combine feeding a DEPTH-stage valid/ready pipeline with saturating nonzero counters.
module gated_combine_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHANNELS*WIDTH-1:0]   in_a,
  input  logic [CHANNELS*WIDTH-1:0]   in_d,
  input  logic [1:0]                  mode,
  input  logic [CHANNELS-1:0]         ch_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHANNELS*WIDTH-1:0]   out_data,
  output logic [CHANNELS-1:0]         out_nonzero,
  input  logic                        clear_cnt,
  output logic [CHANNELS*CNT_W-1:0]   nz_count,
  output logic                        busy
);
  localparam int CW = CHANNELS*WIDTH;
  localparam int PW = DEPTH*CW;

  logic [CW-1:0]    comb;
  logic [DEPTH-1:0] v, ld, src_v;
  logic [PW-1:0]    pipe, src_d;

  always_comb begin
    comb = '0;
    for (int k = 0; k < CHANNELS; k++)
      comb[k*WIDTH +: WIDTH] = !ch_en[k] ? '0 :
        mode == 2'd0 ? in_a[k*WIDTH +: WIDTH] & in_d[k*WIDTH +: WIDTH] :
        mode == 2'd1 ? in_a[k*WIDTH +: WIDTH] | in_d[k*WIDTH +: WIDTH] :
        mode == 2'd2 ? in_a[k*WIDTH +: WIDTH] ^ in_d[k*WIDTH +: WIDTH] :
                       in_a[k*WIDTH +: WIDTH];
  end

  // A stage can take a new beat unless it and every stage after it are full with the sink stalled.
  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ld
      assign ld[i] = out_ready | ~&v[DEPTH-1:i];
    end
  endgenerate

  assign src_v     = DEPTH'({v, in_valid});
  assign src_d     = PW'({pipe, comb});
  assign in_ready  = ld[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = pipe[PW-1 -: CW];
  assign busy      = |v;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v    <= '0;
      pipe <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++)
        if (ld[s]) begin
          v[s] <= src_v[s];
          if (src_v[s]) pipe[s*CW +: CW] <= src_d[s*CW +: CW];
        end
    end

  always_comb begin
    out_nonzero = '0;
    for (int k = 0; k < CHANNELS; k++)
      out_nonzero[k] = |out_data[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) nz_count <= '0;
    else if (clear_cnt) nz_count <= '0;
    else if (out_valid & out_ready) begin
      for (int k = 0; k < CHANNELS; k++)
        if (out_nonzero[k] && !(&nz_count[k*CNT_W +: CNT_W]))
          nz_count[k*CNT_W +: CNT_W] <= nz_count[k*CNT_W +: CNT_W] + CNT_W'(1);
    end
endmodule
